matrix_operand_loader: RTL
==========================

# matrix_operand_loader

Byte-serial operand loader that assembles one 5x5 signed 8-bit matrix and one signed 8-bit scalar into the flattened operand format consumed by the scalar-multiply ALU stage. The block sits directly upstream of that stage. It accepts 26 bytes over a valid/ready stream: 25 matrix elements, then the scalar. It holds the complete operand set stable behind an output valid/ready handshake until the downstream stage takes it.

## Interface
- ELEM_W, 8, element and scalar width in bits
- N_ELEMS, 25, matrix elements per operand set (5x5)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- clear  input  1  synchronous abort: discard the partial or held operand set
- in_valid  input  1  in_data carries a byte
- in_data  input  ELEM_W  element or scalar byte, two's complement
- in_ready  output  1  loader accepts a byte this cycle
- out_valid  output  1  A_flat and scalar hold a complete operand set
- out_ready  input  1  downstream consumes the operand set
- A_flat  output  ELEM_W*N_ELEMS (200)  flattened matrix; element i at bits [i*8 +: 8], row-major (i = row*5 + col)
- scalar  output  ELEM_W  signed scalar operand
- load_count  output  5  bytes accepted in the current set (0..26)

## Operation
- Two states: LOAD and HOLD. Reset state is LOAD.
- LOAD:
  - in_ready = 1 and out_valid = 0.
  - A byte is accepted when in_valid & in_ready at a rising edge.
  - Accepted byte k (k = load_count before the edge) goes to A_flat[k*8 +: 8] for k = 0..24, or to scalar for k = 25.
  - load_count increments by 1 per accepted byte.
  - Accepting byte 25 moves the block to HOLD.
- HOLD:
  - in_ready = 0 and out_valid = 1. A_flat and scalar are frozen.
  - in_valid is ignored; no bytes are accepted.
  - out_valid & out_ready at an edge moves the block to LOAD with load_count = 0.
  - A_flat and scalar keep their old contents until overwritten byte by byte.
- clear:
  - Any state: next state LOAD, load_count = 0, A_flat = 0, scalar = 0.
  - clear has priority over a simultaneous byte accept or out_ready. The byte is dropped and the held set is lost.
- rst: same effect as clear. Outputs after reset: in_ready = 1, out_valid = 0, A_flat = 0, scalar = 0, load_count = 0.
- in_ready and out_valid are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- No arithmetic is applied to the data. Bytes pass through bit-exact; sign is interpreted only downstream.

## Timing
- Full set: at least 26 accepting cycles. out_valid rises in the cycle after the edge that accepts byte 25.
- Partial-set load_count is visible the cycle after each accept. In HOLD, load_count reads 26.
- Handoff from HOLD to LOAD takes 1 cycle. in_ready rises the cycle after the out_ready edge.
- A byte presented in the same cycle as the out_ready handshake is not accepted, because in_ready = 0 in HOLD.
- Minimum period between operand sets is 27 cycles: 26 accepts plus 1 handoff cycle.
- Gaps in in_valid stall the load indefinitely with no timeout. out_ready held low keeps HOLD indefinitely.
- clear or rst takes effect at the next edge. Outputs reflect the cleared state 1 cycle after assertion.

## Test plan
- Basic load: stream bytes 0x01..0x19, then scalar 0xFE, with in_valid held high. Required: out_valid = 1 the cycle after byte 25; A_flat[7:0] = 0x01; A_flat[199:192] = 0x19; scalar = 0xFE; load_count = 26.
- Bubbles and backpressure:
  - Toggle in_valid randomly during a 26-byte load. Required: only accepted bytes are stored, in order.
  - Hold out_ready = 0 for 10 cycles. Required: outputs are stable and in_ready = 0 throughout.
  - Present bytes while in HOLD. Required: none are stored.
- Handoff: pulse out_ready for 1 cycle while in_valid = 1 with data 0x7F. Required: 0x7F is not accepted that cycle; the next cycle in_ready = 1 and load_count = 0; the following accepted 0x7F lands in A_flat[7:0].
- Back-to-back sets: load set 1 (all 0x80, scalar 0x80), hand off, then load set 2 (all 0x05, scalar 0x03). Required: set 2 appears intact and out_valid rises exactly 27 cycles after set 1's handshake with continuous in_valid.
- Clear mid-load: accept 12 bytes, then assert clear together with in_valid. Required: that byte is dropped; load_count = 0, A_flat = 0, scalar = 0, in_ready = 1 the next cycle; a fresh 26-byte load completes normally.
- Reset in HOLD: assert rst while out_valid = 1 and out_ready = 1. Required: no handshake credit is given; next cycle out_valid = 0, A_flat = 0, scalar = 0, load_count = 0, in_ready = 1.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: byte-serial loader for one 5x5 signed matrix plus a scalar, held behind a valid/ready output
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clear           synchronous abort of the partial or held operand set
//   in_valid/in_ready/in_data    byte stream: 25 row-major elements, then the scalar
//   out_valid/out_ready          operand-set handshake toward the ALU stage
//   A_flat, scalar  assembled operands, element i at A_flat[i*ELEM_W +: ELEM_W]
//   load_count      bytes accepted in the current set (26 while holding)
module matrix_operand_loader #(
    parameter int ELEM_W  = 8,
    parameter int N_ELEMS = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [ELEM_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W*N_ELEMS-1:0] A_flat,
    output logic [ELEM_W-1:0]         scalar,
    output logic [4:0]                load_count
);
    typedef enum logic {LOAD, HOLD} state_t;
    state_t state;
    assign in_ready  = state == LOAD;
    assign out_valid = state == HOLD;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= LOAD;
            load_count <= '0;
            A_flat     <= '0;
            scalar     <= '0;
        end else if (state == LOAD) begin
            if (in_valid) begin
                // the byte after the last matrix element is the scalar and completes the set
                if (load_count == 5'(N_ELEMS)) begin
                    scalar <= in_data;
                    state  <= HOLD;
                end else begin
                    A_flat[int'(load_count)*ELEM_W +: ELEM_W] <= in_data;
                end
                load_count <= load_count + 5'd1;
            end
        end else if (out_ready) begin
            // matrix and scalar are left in place and get overwritten byte by byte
            state      <= LOAD;
            load_count <= '0;
        end
    end
endmodule
